rr_encoder_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index, so downstream logic never sees invalid or multi-hot codes.
- Holds the grant until the holder signals done, drops its request, or exceeds a hold timeout.
- Sits in front of any shared datapath selected by a 3-bit index: mux select, shared encoder output bus, etc.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 30 +++
 rtl/rr_encoder_arbiter.sv | 111 +++++++++++
 tb/tb_rr_encoder_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant encoder: sizes, FSM state type
// and the one-hot to binary index helper used by every encoder consumer.
package arb_pkg;

  localparam int N    = 8;
  localparam int IDXW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // OR-reduction encoder: exact for one-hot input, returns 0 for all-zero.
  function automatic logic [IDXW-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first unmasked request at or after ptr,
// scanning upward and wrapping. Rotate, isolate lowest bit, encode, un-rotate.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  logic [N-1:0]    mask,
  output logic [IDXW-1:0] win_idx,
  output logic            win_any
);

  logic [N-1:0]    eff;
  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [N-1:0]    low;
  logic [IDXW-1:0] rot_idx;

  always_comb begin
    eff = req & ~mask;
    // Rotating by ptr puts requester ptr at bit 0 of rot.
    dbl = {eff, eff};
    rot = dbl[{1'b0, ptr} +: N];
    low = rot & (~rot + N'(1));
    rot_idx = onehot_to_idx(low);
    win_idx = rot_idx + ptr;
    win_any = |eff;
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded
// index, done/drop release, hold timeout and same-edge hand-off.
module rr_encoder_arbiter #(
  parameter int N        = arb_pkg::N,
  parameter int IDXW     = arb_pkg::IDXW,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  import arb_pkg::*;

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic [IDXW-1:0] pick_ptr;
  logic [N-1:0]    pick_mask;
  logic [IDXW-1:0] win_idx;
  logic            win_any;
  logic [N-1:0]    win_oh;
  logic            limit_hit;
  logic            holder_drop;
  logic            release_now;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pick_ptr    = ptr;
    pick_mask   = '0;
    limit_hit   = 1'b0;
    holder_drop = 1'b0;
    release_now = 1'b0;
    if (state == BUSY) begin
      // On release the new ptr is used in the same edge, holder masked out.
      pick_ptr    = grant_idx + IDXW'(1);
      pick_mask   = grant;
      limit_hit   = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));
      holder_drop = !req[grant_idx];
      release_now = done || holder_drop || limit_hit;
    end
  end

  rr_pick u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .mask    (pick_mask),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign win_oh = N'(1) << win_idx;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            grant       <= win_oh;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= HCW'(1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr     <= grant_idx + IDXW'(1);
            timeout <= limit_hit && !done && !holder_drop;
            if (win_any) begin
              grant       <= win_oh;
              grant_idx   <= win_idx;
              grant_valid <= 1'b1;
              hold_cnt    <= HCW'(1);
            end else begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              hold_cnt    <= '0;
              state       <= IDLE;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter: hand-computed grants, hand-off,
// wrap-around, hold timeout, holder drop and asynchronous reset.
module tb_rr_encoder_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int vectors;
  int errors;

  rr_encoder_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    check({tag, ".grant"}, 32'(grant), 32'(oh));
    check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    check({tag, ".valid"}, 32'(grant_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".idx"}, 32'(grant_idx), 32'd0);
    check({tag, ".valid"}, 32'(grant_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] exp_idx;
    vectors = 0;
    errors  = 0;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    #12;
    check_idle("reset");
    check("reset.timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Single requester, then done; ptr ends at 3.
    req = 8'b0000_0100;
    tick();
    check_grant("single", 3'd2);
    done = 1'b1;
    tick();
    check_idle("single_done");
    check("single_done.timeout", 32'(timeout), 32'd0);
    done = 1'b0;
    req  = 8'b0000_1010;
    tick();
    check_grant("ptr3", 3'd3);
    done = 1'b1;
    req  = 8'h00;
    tick();
    check_idle("ptr3_done");
    done = 1'b0;
    rst  = 1'b1;
    #1;
    rst  = 1'b0;

    // Two requesters alternating with done held, no bubble.
    req = 8'b1000_0001;
    tick();
    check_grant("alt0", 3'd0);
    done = 1'b1;
    tick();
    check_grant("alt1", 3'd7);
    tick();
    check_grant("alt2", 3'd0);
    tick();
    check_grant("alt3", 3'd7);
    done = 1'b0;
    req  = 8'h00;
    tick();
    check_idle("alt_end");

    // All requesting with done: full wrap 0..7,0.
    req  = 8'hFF;
    done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_idx = 3'(k);
      check_grant($sformatf("wrap%0d", k), exp_idx);
    end
    done = 1'b0;
    req  = 8'h00;
    tick();
    check_idle("wrap_end");

    // Timeout with sole requester 4 (ptr=1 now).
    req = 8'b0001_0000;
    tick();
    check_grant("to_load", 3'd4);
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("to_hold%0d.idx", k), 32'(grant_idx), 32'd4);
      check($sformatf("to_hold%0d.timeout", k), 32'(timeout), 32'd0);
    end
    tick();
    check("to_fire.timeout", 32'(timeout), 32'd1);
    check_idle("to_fire");
    tick();
    check("to_after.timeout", 32'(timeout), 32'd0);
    check_grant("to_regrant", 3'd4);

    // Timeout with a second requester: hand-off to 5 on the same edge.
    req = 8'b0011_0000;
    for (int k = 0; k < 15; k++) tick();
    check_grant("to2_hold", 3'd4);
    check("to2_hold.timeout", 32'(timeout), 32'd0);
    tick();
    check_grant("to2_fire", 3'd5);
    check("to2_fire.timeout", 32'(timeout), 32'd1);
    tick();
    check("to2_after.timeout", 32'(timeout), 32'd0);
    check_grant("to2_after", 3'd5);

    // Holder 3 drops its request while 6 waits.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 8'b0100_1000;
    tick();
    check_grant("drop_load", 3'd3);
    req = 8'b0100_0000;
    tick();
    check_grant("drop_move", 3'd6);
    check("drop_move.timeout", 32'(timeout), 32'd0);

    // done coincides with the hold limit: done wins, no timeout.
    for (int k = 0; k < 15; k++) tick();
    check_grant("coin_hold", 3'd6);
    done = 1'b1;
    tick();
    check("coin.timeout", 32'(timeout), 32'd0);
    check_idle("coin");
    done = 1'b0;
    req  = 8'h00;

    // Asynchronous reset mid-grant, then first grant from ptr=0.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 8'b0010_0000;
    tick();
    check_grant("areset_load", 3'd5);
    #2;
    rst = 1'b1;
    #1;
    check_idle("areset_now");
    check("areset_now.timeout", 32'(timeout), 32'd0);
    req = 8'b0010_0001;
    tick();
    check_idle("areset_held");
    rst = 1'b0;
    tick();
    check_grant("areset_first", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
